// File: rtl/chroma_key_mixer.sv
// Streaming chroma-key compositor: aligns foreground and background frames, swaps keyed fg pixels
// for bg pixels through a two-stage stall-as-a-whole pipeline, and keeps per-frame key statistics.
module chroma_key_mixer #(
    parameter int CW     = 8,
    parameter int NUM_CH = 3,
    localparam int PW    = CW * NUM_CH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cfg_write,
    input  logic [1:0]    cfg_addr,
    input  logic [31:0]   cfg_writedata,
    input  logic [PW-1:0] fg_data,
    input  logic          fg_valid,
    input  logic          fg_sop,
    input  logic          fg_eop,
    output logic          fg_ready,
    input  logic [PW-1:0] bg_data,
    input  logic          bg_valid,
    input  logic          bg_sop,
    input  logic          bg_eop,
    output logic          bg_ready,
    output logic [PW-1:0] out_data,
    output logic          out_valid,
    output logic          out_sop,
    output logic          out_eop,
    input  logic          out_ready,
    output logic [31:0]   frame_key_count,
    output logic [15:0]   sync_err_count
);

    typedef enum logic [0:0] {
        SEEK = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic logic key_hit(input logic [PW-1:0] px, input logic [PW-1:0] key,
                                     input logic [PW-1:0] tol);
        logic          h;
        logic [CW-1:0] a;
        logic [CW-1:0] b;
        logic [CW-1:0] d;
        h = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            a = px[c*CW +: CW];
            b = key[c*CW +: CW];
            d = (a >= b) ? (a - b) : (b - a);
            if (d > tol[c*CW +: CW]) begin
                h = 1'b0;
            end else begin
                h = h;
            end
        end
        return h;
    endfunction

    function automatic logic [PW-1:0] mix(input logic [1:0] mode, input logic hit,
                                          input logic [PW-1:0] fg, input logic [PW-1:0] bg);
        logic [PW-1:0] r;
        case (mode)
            2'd0:    r = fg;
            2'd1:    r = bg;
            2'd2:    r = hit ? bg : fg;
            2'd3:    r = hit ? {PW{1'b1}} : {PW{1'b0}};
            default: r = fg;
        endcase
        return r;
    endfunction

    state_t        state_q,     state_d;
    logic [PW-1:0] key_pend_q,  key_pend_d;
    logic [PW-1:0] tol_pend_q,  tol_pend_d;
    logic [1:0]    mode_pend_q, mode_pend_d;
    logic [PW-1:0] key_act_q,   key_act_d;
    logic [PW-1:0] tol_act_q,   tol_act_d;
    logic [1:0]    mode_act_q,  mode_act_d;
    logic          s1_valid_q,  s1_valid_d;
    logic [PW-1:0] s1_fg_q,     s1_fg_d;
    logic [PW-1:0] s1_bg_q,     s1_bg_d;
    logic          s1_sop_q,    s1_sop_d;
    logic          s1_eop_q,    s1_eop_d;
    logic          s1_hit_q,    s1_hit_d;
    logic [1:0]    s1_mode_q,   s1_mode_d;
    logic          out_valid_q, out_valid_d;
    logic [PW-1:0] out_data_q,  out_data_d;
    logic          out_sop_q,   out_sop_d;
    logic          out_eop_q,   out_eop_d;
    logic [31:0]   running_q,   running_d;
    logic [31:0]   frame_cnt_q, frame_cnt_d;
    logic [15:0]   sync_err_q,  sync_err_d;

    logic          en_s;
    logic          join_s;
    logic          accept_s;
    logic          drop_fg_s;
    logic          drop_bg_s;
    logic          sop_start_s;
    logic          mismatch_s;
    logic [PW-1:0] key_eff_s;
    logic [PW-1:0] tol_eff_s;
    logic [1:0]    mode_eff_s;
    logic          hit_s;
    logic [31:0]   run_base_s;
    logic [31:0]   run_sum_s;
    logic [16:0]   sync_sum_s;

    assign en_s        = !out_valid_q || out_ready;
    assign join_s      = fg_valid && bg_valid && en_s;
    assign sop_start_s = accept_s && fg_sop && bg_sop;
    assign mismatch_s  = (fg_sop != bg_sop) || (fg_eop != bg_eop);
    // The frame-opening pixel already sees the pending config it is about to latch.
    assign key_eff_s   = sop_start_s ? key_pend_q  : key_act_q;
    assign tol_eff_s   = sop_start_s ? tol_pend_q  : tol_act_q;
    assign mode_eff_s  = sop_start_s ? mode_pend_q : mode_act_q;
    assign hit_s       = key_hit(fg_data, key_eff_s, tol_eff_s);
    assign run_base_s  = sop_start_s ? 32'd0 : running_q;
    assign run_sum_s   = run_base_s + {31'd0, hit_s};
    assign sync_sum_s  = {1'b0, sync_err_q} + {16'd0, drop_fg_s} + {16'd0, drop_bg_s};

    assign fg_ready        = accept_s || drop_fg_s;
    assign bg_ready        = accept_s || drop_bg_s;
    assign out_data        = out_data_q;
    assign out_valid       = out_valid_q;
    assign out_sop         = out_sop_q;
    assign out_eop         = out_eop_q;
    assign frame_key_count = frame_cnt_q;
    assign sync_err_count  = sync_err_q;

    generate
        if (PW < 32) begin : g_unused
            logic unused_cfg_bits_s;
            assign unused_cfg_bits_s = ^cfg_writedata[31:PW];
        end
    endgenerate

    // Input handshake: pair acceptance, or discard of non-sop pixels while seeking alignment.
    always_comb begin
        accept_s  = 1'b0;
        drop_fg_s = 1'b0;
        drop_bg_s = 1'b0;
        if (reset) begin
            accept_s = 1'b0;
        end else begin
            case (state_q)
                SEEK: begin
                    if (join_s && fg_sop && bg_sop) begin
                        accept_s = 1'b1;
                    end else begin
                        drop_fg_s = fg_valid && !fg_sop;
                        drop_bg_s = bg_valid && !bg_sop;
                    end
                end
                RUN:     accept_s = join_s;
                default: accept_s = 1'b0;
            endcase
        end
    end

    // Next-state for config, alignment FSM, pipeline and statistics.
    always_comb begin
        state_d     = state_q;
        key_pend_d  = key_pend_q;
        tol_pend_d  = tol_pend_q;
        mode_pend_d = mode_pend_q;
        key_act_d   = key_act_q;
        tol_act_d   = tol_act_q;
        mode_act_d  = mode_act_q;
        s1_valid_d  = s1_valid_q;
        s1_fg_d     = s1_fg_q;
        s1_bg_d     = s1_bg_q;
        s1_sop_d    = s1_sop_q;
        s1_eop_d    = s1_eop_q;
        s1_hit_d    = s1_hit_q;
        s1_mode_d   = s1_mode_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sop_d   = out_sop_q;
        out_eop_d   = out_eop_q;
        running_d   = running_q;
        frame_cnt_d = frame_cnt_q;
        sync_err_d  = sync_sum_s[16] ? 16'hFFFF : sync_sum_s[15:0];

        if (cfg_write) begin
            case (cfg_addr)
                2'd0:    key_pend_d  = cfg_writedata[PW-1:0];
                2'd1:    tol_pend_d  = cfg_writedata[PW-1:0];
                2'd2:    mode_pend_d = cfg_writedata[1:0];
                default: mode_pend_d = mode_pend_q;
            endcase
        end else begin
            mode_pend_d = mode_pend_q;
        end

        if (sop_start_s) begin
            key_act_d  = key_pend_q;
            tol_act_d  = tol_pend_q;
            mode_act_d = mode_pend_q;
        end else begin
            mode_act_d = mode_act_q;
        end

        if (en_s) begin
            s1_valid_d  = accept_s;
            s1_fg_d     = fg_data;
            s1_bg_d     = bg_data;
            s1_sop_d    = fg_sop;
            s1_eop_d    = fg_eop;
            s1_hit_d    = hit_s;
            s1_mode_d   = mode_eff_s;
            out_valid_d = s1_valid_q;
            out_data_d  = mix(s1_mode_q, s1_hit_q, s1_fg_q, s1_bg_q);
            out_sop_d   = s1_valid_q && s1_sop_q;
            out_eop_d   = s1_valid_q && s1_eop_q;
        end else begin
            s1_valid_d = s1_valid_q;
        end

        if (accept_s) begin
            state_d = (fg_eop || bg_eop || mismatch_s) ? SEEK : RUN;
            if (fg_eop) begin
                frame_cnt_d = run_sum_s;
                running_d   = 32'd0;
            end else begin
                running_d   = run_sum_s;
            end
        end else begin
            state_d = state_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SEEK;
            key_pend_q  <= {PW{1'b0}};
            tol_pend_q  <= {PW{1'b0}};
            mode_pend_q <= 2'd2;
            key_act_q   <= {PW{1'b0}};
            tol_act_q   <= {PW{1'b0}};
            mode_act_q  <= 2'd2;
            s1_valid_q  <= 1'b0;
            s1_fg_q     <= {PW{1'b0}};
            s1_bg_q     <= {PW{1'b0}};
            s1_sop_q    <= 1'b0;
            s1_eop_q    <= 1'b0;
            s1_hit_q    <= 1'b0;
            s1_mode_q   <= 2'd2;
            out_valid_q <= 1'b0;
            out_data_q  <= {PW{1'b0}};
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            running_q   <= 32'd0;
            frame_cnt_q <= 32'd0;
            sync_err_q  <= 16'd0;
        end else begin
            state_q     <= state_d;
            key_pend_q  <= key_pend_d;
            tol_pend_q  <= tol_pend_d;
            mode_pend_q <= mode_pend_d;
            key_act_q   <= key_act_d;
            tol_act_q   <= tol_act_d;
            mode_act_q  <= mode_act_d;
            s1_valid_q  <= s1_valid_d;
            s1_fg_q     <= s1_fg_d;
            s1_bg_q     <= s1_bg_d;
            s1_sop_q    <= s1_sop_d;
            s1_eop_q    <= s1_eop_d;
            s1_hit_q    <= s1_hit_d;
            s1_mode_q   <= s1_mode_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            running_q   <= running_d;
            frame_cnt_q <= frame_cnt_d;
            sync_err_q  <= sync_err_d;
        end
    end

endmodule

// File: tb/tb_chroma_key_mixer.sv
// Scoreboard bench for chroma_key_mixer: directed frames, expected pixels queued at stimulus time
// and popped by an output monitor.
module tb_chroma_key_mixer;

    typedef struct packed {
        logic [23:0] data;
        logic        sop;
        logic        eop;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_write;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_writedata;
    logic [23:0] fg_data, bg_data, out_data;
    logic        fg_valid, fg_sop, fg_eop, fg_ready;
    logic        bg_valid, bg_sop, bg_eop, bg_ready;
    logic        out_valid, out_sop, out_eop, out_ready;
    logic [31:0] frame_key_count;
    logic [15:0] sync_err_count;

    beat_t fg_q[$];
    beat_t bg_q[$];
    beat_t exp_q[$];
    int    checks = 0;
    int    fails  = 0;
    int    cyc_cnt = 0;
    int    acc_cyc = 0;
    int    ov_cyc = 0;
    bit    acc_seen = 1'b0;
    bit    ov_seen = 1'b0;
    bit    tog = 1'b0;

    chroma_key_mixer #(.CW(8), .NUM_CH(3)) dut (
        .clk(clk), .reset(reset),
        .cfg_write(cfg_write), .cfg_addr(cfg_addr), .cfg_writedata(cfg_writedata),
        .fg_data(fg_data), .fg_valid(fg_valid), .fg_sop(fg_sop), .fg_eop(fg_eop), .fg_ready(fg_ready),
        .bg_data(bg_data), .bg_valid(bg_valid), .bg_sop(bg_sop), .bg_eop(bg_eop), .bg_ready(bg_ready),
        .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
        .out_ready(out_ready), .frame_key_count(frame_key_count), .sync_err_count(sync_err_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Output monitor: pops one expected beat per output transfer.
    always @(negedge clk) begin
        beat_t e;
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_out actual=%0h required=none", out_data);
            end else begin
                e = exp_q.pop_front();
                chk("out_beat", {38'd0, out_sop, out_eop, out_data}, {38'd0, e.sop, e.eop, e.data});
            end
        end
        if (out_valid && !ov_seen) begin
            ov_seen = 1'b1;
            ov_cyc  = cyc_cnt;
        end
    end

    task automatic push_pair(input logic [23:0] f, input logic [23:0] b, input logic s,
                             input logic e, input logic [23:0] x);
        fg_q.push_back('{data: f, sop: s, eop: e});
        bg_q.push_back('{data: b, sop: s, eop: e});
        exp_q.push_back('{data: x, sop: s, eop: e});
    endtask

    // Reference frame: key 00FF00 / tol 101010 hits px 0, 2 and 3.
    task automatic t1_frame(input logic [23:0] b, input bit all_bg);
        logic [23:0] fgv [4];
        logic [3:0]  hitm;
        fgv[0] = 24'h00F000;
        fgv[1] = 24'hFF0000;
        fgv[2] = 24'h10EF10;
        fgv[3] = 24'h00FF00;
        hitm   = 4'b1101;
        for (int i = 0; i < 4; i++) begin
            push_pair(fgv[i], b, (i == 0), (i == 3), (all_bg || hitm[i]) ? b : fgv[i]);
        end
    endtask

    task automatic cfg(input logic [1:0] a, input logic [31:0] d);
        cfg_write = 1'b1;
        cfg_addr = a;
        cfg_writedata = d;
        @(posedge clk); #1;
        cfg_write = 1'b0;
    endtask

    task automatic run_streams(input int max_cycles);
        int  n = 0;
        bit  fr, br;
        while ((fg_q.size() > 0 || bg_q.size() > 0) && n < max_cycles) begin
            fg_valid = (fg_q.size() > 0);
            bg_valid = (bg_q.size() > 0);
            if (fg_valid) begin
                fg_data = fg_q[0].data; fg_sop = fg_q[0].sop; fg_eop = fg_q[0].eop;
            end
            if (bg_valid) begin
                bg_data = bg_q[0].data; bg_sop = bg_q[0].sop; bg_eop = bg_q[0].eop;
            end
            @(negedge clk);
            fr = fg_ready;
            br = bg_ready;
            if (fr && fg_valid && fg_sop && bg_valid && bg_sop && !acc_seen) begin
                acc_seen = 1'b1;
                acc_cyc  = cyc_cnt;
            end
            @(posedge clk); #1;
            if (fr && fg_valid) void'(fg_q.pop_front());
            if (br && bg_valid) void'(bg_q.pop_front());
            if (tog) out_ready = ~out_ready;
            n++;
        end
        fg_valid = 1'b0;
        bg_valid = 1'b0;
        if (n >= max_cycles) begin
            checks++;
            fails++;
            $display("FAIL stream_timeout actual=%0d required=<%0d", n, max_cycles);
            fg_q.delete();
            bg_q.delete();
        end
    endtask

    task automatic drain();
        int n = 0;
        tog = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() > 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            fails++;
            $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; cfg_write = 1'b0; cfg_addr = 2'd0; cfg_writedata = 32'd0;
        fg_data = 24'd0; fg_valid = 1'b0; fg_sop = 1'b0; fg_eop = 1'b0;
        bg_data = 24'd0; bg_valid = 1'b0; bg_sop = 1'b0; bg_eop = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        fg_valid = 1'b1; bg_valid = 1'b1; fg_sop = 1'b1; bg_sop = 1'b1;
        @(negedge clk);
        chk("rst_fg_ready", {63'd0, fg_ready}, 64'd0);
        chk("rst_bg_ready", {63'd0, bg_ready}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_data", {40'd0, out_data}, 64'd0);
        chk("rst_frame_cnt", {32'd0, frame_key_count}, 64'd0);
        chk("rst_sync_err", {48'd0, sync_err_count}, 64'd0);
        @(posedge clk); #1;
        fg_valid = 1'b0; bg_valid = 1'b0; fg_sop = 1'b0; bg_sop = 1'b0;
        reset = 1'b0;

        // T1: keyed composite and latency
        cfg(2'd0, 32'h0000FF00);
        cfg(2'd1, 32'h00101010);
        cfg(2'd2, 32'd2);
        acc_seen = 1'b0;
        ov_seen  = 1'b0;
        t1_frame(24'hAAAAAA, 1'b0);
        run_streams(40);
        drain();
        chk("t1_frame_cnt", {32'd0, frame_key_count}, 64'd3);
        chk("t1_latency", 64'(ov_cyc - acc_cyc), 64'd2);
        chk("t1_sync_err", {48'd0, sync_err_count}, 64'd0);

        // T2: backpressure toggling
        tog = 1'b1;
        t1_frame(24'hAAAAAA, 1'b0);
        run_streams(60);
        drain();
        chk("t2_frame_cnt", {32'd0, frame_key_count}, 64'd3);

        // T3: two misaligned fg pixels ahead of the frame
        fg_q.push_back('{data: 24'h123456, sop: 1'b0, eop: 1'b0});
        fg_q.push_back('{data: 24'h654321, sop: 1'b0, eop: 1'b0});
        t1_frame(24'hAAAAAA, 1'b0);
        run_streams(40);
        drain();
        chk("t3_sync_err", {48'd0, sync_err_count}, 64'd2);
        chk("t3_frame_cnt", {32'd0, frame_key_count}, 64'd3);

        // T4: mode change mid-frame applies to the next frame only
        t1_frame(24'hAAAAAA, 1'b0);
        t1_frame(24'h555555, 1'b1);
        fork
            run_streams(60);
            begin
                @(posedge clk); #1;
                cfg(2'd2, 32'd1);
            end
        join
        drain();
        chk("t4_frame_cnt", {32'd0, frame_key_count}, 64'd3);

        // T5: mask view with zero tolerance
        cfg(2'd2, 32'd3);
        cfg(2'd1, 32'd0);
        push_pair(24'h00FF00, 24'h777777, 1'b1, 1'b0, 24'hFFFFFF);
        push_pair(24'h00FF01, 24'h777777, 1'b0, 1'b1, 24'h000000);
        run_streams(40);
        drain();
        chk("t5_frame_cnt", {32'd0, frame_key_count}, 64'd1);

        // T6: reset mid-frame under backpressure
        out_ready = 1'b0;
        fg_valid = 1'b1; bg_valid = 1'b1;
        fg_data = 24'h111111; bg_data = 24'h222222;
        fg_sop = 1'b1; bg_sop = 1'b1; fg_eop = 1'b0; bg_eop = 1'b0;
        @(posedge clk); #1;
        fg_sop = 1'b0; bg_sop = 1'b0;
        @(posedge clk); #1;
        fg_valid = 1'b0; bg_valid = 1'b0;
        @(negedge clk);
        chk("t6_stalled_valid", {63'd0, out_valid}, 64'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("t6_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("t6_rst_frame_cnt", {32'd0, frame_key_count}, 64'd0);
        chk("t6_rst_sync_err", {48'd0, sync_err_count}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        out_ready = 1'b1;
        push_pair(24'h000000, 24'hBBBBBB, 1'b1, 1'b0, 24'hBBBBBB);
        push_pair(24'h010000, 24'hBBBBBB, 1'b0, 1'b1, 24'h010000);
        run_streams(40);
        drain();
        chk("t6_frame_cnt", {32'd0, frame_key_count}, 64'd1);
        chk("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
